serial_sub_ctrl: RTL and testbench

//   Bit-serial subtract controller. Time-shares one 1-bit full subtractor
//   (full_sub_gatelevel) across a WIDTH-bit operand pair, LSB first.

---
 rtl/sub_ctrl_pkg.sv | 13 +
 rtl/full_sub_gatelevel.sv | 25 ++
 rtl/serial_sub_ctrl.sv | 97 +++++++++
 tb/tb_serial_sub_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtract controller: FSM state encoding
// and the default operand width.
package sub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_sub_gatelevel.sv
// One-bit full subtractor built from gate primitives: d = a - b - c,
// borrow set when the slice needs to borrow from the next bit.
module full_sub_gatelevel (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d,
  output logic borrow
);

  logic axb;
  logic na;
  logic naxb;
  logic t0;
  logic t1;

  xor g_x0 (axb, a, b);
  xor g_x1 (d, axb, c);
  not g_n0 (na, a);
  and g_a0 (t0, na, b);
  not g_n1 (naxb, axb);
  and g_a1 (t1, naxb, c);
  or  g_o0 (borrow, t0, t1);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: shares one full_sub_gatelevel cell across
// WIDTH slices, LSB first, with the borrow held in a flop between slices.
module serial_sub_ctrl
  import sub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic [1:0]       state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is a request sampled only while IDLE; the edge that sees
  // start == 1 in IDLE is the accept edge and captures a_in/b_in/bin. There is
  // no back-pressure signal: busy/done report progress and requests made in
  // RUN or DONE are dropped, not queued.
  state_e           state_q;
  logic [WIDTH-1:0] sh_a_q;
  logic [WIDTH-1:0] sh_b_q;
  logic [WIDTH-1:0] sh_d_q;
  logic [WIDTH-1:0] sh_d_d;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_out_q;

  logic cell_d;
  logic cell_borrow;

  full_sub_gatelevel u_cell (
    .a      (sh_a_q[0]),
    .b      (sh_b_q[0]),
    .c      (borrow_q),
    .d      (cell_d),
    .borrow (cell_borrow)
  );

  assign sh_d_d = {cell_d, sh_d_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sh_a_q       <= '0;
      sh_b_q       <= '0;
      sh_d_q       <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sh_a_q   <= a_in;
            sh_b_q   <= b_in;
            borrow_q <= bin;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          sh_a_q   <= sh_a_q >> 1;
          sh_b_q   <= sh_b_q >> 1;
          sh_d_q   <= sh_d_d;
          borrow_q <= cell_borrow;
          cnt_q    <= cnt_q + CW'(1);
          // Result registers update only here, so they never show partial sums.
          if (cnt_q == LAST) begin
            diff_q       <= sh_d_d;
            borrow_out_q <= cell_borrow;
            state_q      <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed cases with literal results,
// randomized traffic against a timing/arithmetic model, and a 1-bit cell sweep.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic [1:0]   state_o;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .state_o    (state_o)
  );

  logic ca = 1'b0, cb = 1'b0, cc = 1'b0;
  logic cd, cbo;
  full_sub_gatelevel u_cell_chk (.a(ca), .b(cb), .c(cc), .d(cd), .borrow(cbo));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a transaction accepted at edge t is busy for edges
  // t..t+W-1, shows done after edge t+W, and blocks new accepts until t+W+2.
  int           m_e = 0;
  int           m_t = -1;
  logic [W-1:0] m_pend_diff = '0;
  logic         m_pend_bout = 1'b0;
  logic [W-1:0] m_diff = '0;
  logic         m_bout = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t    <= -1;
      m_diff <= '0;
      m_bout <= 1'b0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else begin
      int ne, nt, k;
      logic [W-1:0] pd;
      logic pb;
      ne = m_e + 1;
      nt = m_t;
      pd = m_pend_diff;
      pb = m_pend_bout;
      if (!(nt >= 0 && ne - nt <= W + 1) && start) begin
        nt = ne;
        pd = W'(int'(a_in) - int'(b_in) - int'(bin));
        pb = (int'(a_in) < int'(b_in) + int'(bin));
      end
      k = (nt >= 0) ? ne - nt : W + 100;
      m_e         <= ne;
      m_t         <= nt;
      m_pend_diff <= pd;
      m_pend_bout <= pb;
      m_busy      <= (k >= 0 && k <= W - 1);
      m_done      <= (k == W);
      if (k == W) begin
        m_diff <= pd;
        m_bout <= pb;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("diff", 32'(diff), 32'(m_diff));
      chk("borrow_out", 32'(borrow_out), 32'(m_bout));
    end
  end

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         input logic [W-1:0] ed, input logic eb, input string nm);
    int n, nbusy;
    logic got;
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b; bin = bi;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); bin = 1'($urandom);
    nbusy = int'(busy);
    n = 0;
    got = 1'b0;
    while (!got && n < 3 * W) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) got = 1'b1;
      else nbusy += int'(busy);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done expected=done_within_%0d", nm, 3 * W);
    end else begin
      chk({nm, "_latency"}, 32'(n), 32'(W));
      chk({nm, "_busy_cycles"}, 32'(nbusy), 32'(W));
      chk({nm, "_diff"}, 32'(diff), 32'(ed));
      chk({nm, "_borrow"}, 32'(borrow_out), 32'(eb));
    end
  endtask

  initial begin
    int ndone, last_i;
    logic [W-1:0] seen_diff;

    // 1. reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_diff", 32'(diff), 32'h00);
    chk("reset_borrow", 32'(borrow_out), 32'd0);
    chk("reset_state", 32'(state_o), 32'd0);

    // 2-4. directed arithmetic cases
    run_one(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "t2");
    run_one(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "t3");
    run_one(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, "t4a");
    run_one(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, "t4b");

    // 5. second start during RUN is dropped
    @(negedge clk);
    start = 1'b1; a_in = 8'h5A; b_in = 8'h3C; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; a_in = 8'h00; b_in = 8'h01; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    seen_diff = '0;
    repeat (20) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        seen_diff = diff;
      end
    end
    chk("t5_done_count", 32'(ndone), 32'd1);
    chk("t5_diff", 32'(seen_diff), 32'h1E);

    // 5b. reset in the middle of a run: prior result 1E must clear at once
    @(negedge clk);
    start = 1'b1; a_in = 8'h00; b_in = 8'h01; bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    chk("t5_rst_diff", 32'(diff), 32'h00);
    chk("t5_rst_borrow", 32'(borrow_out), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t5_rst_no_done", 32'(ndone), 32'd0);

    // 6. start held high: done every W+2 cycles
    @(negedge clk);
    start = 1'b1; a_in = 8'h5A; b_in = 8'h3C; bin = 1'b0;
    ndone = 0;
    last_i = -1;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("t6_diff", 32'(diff), 32'h1E);
        if (last_i >= 0) chk("t6_period", 32'(i - last_i), 32'(W + 2));
        else chk("t6_first_latency", 32'(i), 32'(W));
        last_i = i;
      end
    end
    chk("t6_done_count", 32'(ndone), 32'd3);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // random traffic against the model, with occasional resets
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      #2;
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 2) == 0);
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      bin   = 1'($urandom);
    end
    @(negedge clk);
    #2 rst = 1'b0; start = 1'b0;
    repeat (W + 4) @(negedge clk);
    cmp_en = 1'b0;

    // 7. exhaustive 1-bit cell sweep
    for (int v = 0; v < 8; v++) begin
      int r;
      ca = v[2]; cb = v[1]; cc = v[0];
      #1;
      r = int'(ca) - int'(cb) - int'(cc);
      chk($sformatf("cell_d_%0d", v), 32'(cd), 32'(r & 1));
      chk($sformatf("cell_borrow_%0d", v), 32'(cbo), 32'(r < 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
